// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter.
// Provides the arbiter state encoding and the memory word width.
package mem_arb_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_FETCH,
        ARB_DATA
    } arb_state_t;

endpackage

// File: rtl/arb_watchdog.sv
// Bus-timeout watchdog for the memory port arbiter.
// Ports: clk, reset (sync, active-high), clear (restart count),
//        enable (count this cycle), expire (TIMEOUT-th enabled cycle).
module arb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    if (TIMEOUT == 0) begin : g_off
        logic unused_wd;
        assign unused_wd = ^{clk, reset, clear, enable};
        assign expire    = 1'b0;
    end else begin : g_on
        localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

        logic [CW-1:0] wd_cnt;

        // wd_cnt holds the number of busy cycles already elapsed, so the
        // current cycle is the last one allowed when it equals TIMEOUT-1.
        assign expire = enable & (wd_cnt == CW'(TIMEOUT - 1));

        always_ff @(posedge clk) begin
            if (reset) begin
                wd_cnt <= '0;
            end else if (clear) begin
                wd_cnt <= '0;
            end else if (enable) begin
                wd_cnt <= wd_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch and memory stages.
// Ports: if_* fetch side, d_* data side, mem_* registered memory port,
//        stall_if/stall_mem to hazard unit, bus_err sticky timeout flag.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [WORD_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic [WORD_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              bus_err
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 2);

    arb_state_t      state;
    logic [SC_W-1:0] starve_cnt;
    logic            flush_pend;

    logic idle;
    logic busy;
    logic f_live;
    logic f_want;
    logic d_want;
    logic starved;
    logic grant_d;
    logic grant_f;
    logic wd_expire;
    logic finish;
    logic abort;
    logic drop;

    assign idle    = (state == ARB_IDLE);
    assign busy    = ~idle;
    assign f_live  = if_req & ~if_flush;
    // A requester still showing its done pulse is retiring, not asking again.
    assign f_want  = f_live & ~if_done;
    assign d_want  = d_req & ~d_done;
    assign starved = f_live & (starve_cnt == SC_W'(STARVE_LIMIT));
    assign grant_d = idle & d_want & ~starved;
    assign grant_f = idle & ~grant_d & f_want;
    // mem_ready wins over a coincident watchdog expiry.
    assign finish  = busy & (mem_ready | wd_expire);
    assign abort   = busy & ~mem_ready & wd_expire;
    // A flush arriving in the completing cycle also cancels the fetch.
    assign drop    = flush_pend | if_flush;

    assign stall_if  = if_req & ~if_done & ~if_flush;
    assign stall_mem = d_req & ~d_done;

    arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wd (
        .clk    (clk),
        .reset  (reset),
        .clear  (grant_d | grant_f),
        .enable (busy),
        .expire (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_done    <= 1'b0;
            if_rdata   <= '0;
            d_done     <= 1'b0;
            d_rdata    <= '0;
            bus_err    <= 1'b0;
            flush_pend <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            bus_err <= bus_err | abort;

            unique case (state)
                ARB_IDLE: begin
                    if (grant_d) begin
                        state     <= ARB_DATA;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end else if (grant_f) begin
                        state     <= ARB_FETCH;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                    end
                end
                ARB_FETCH: begin
                    if (finish) begin
                        state      <= ARB_IDLE;
                        mem_req    <= 1'b0;
                        flush_pend <= 1'b0;
                        if (!drop) begin
                            if_done  <= 1'b1;
                            if_rdata <= abort ? '0 : mem_rdata;
                        end
                    end else if (if_flush) begin
                        flush_pend <= 1'b1;
                    end
                end
                ARB_DATA: begin
                    if (finish) begin
                        state   <= ARB_IDLE;
                        mem_req <= 1'b0;
                        d_done  <= 1'b1;
                        if (abort) begin
                            d_rdata <= '0;
                        end else if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state   <= ARB_IDLE;
                    mem_req <= 1'b0;
                end
            endcase

            if (!if_req || grant_f) begin
                starve_cnt <= '0;
            end else if (grant_d && f_live) begin
                starve_cnt <= starve_cnt + SC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic checked against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int ADDR_W       = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall_if;
    logic        stall_mem;
    logic        bus_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .STARVE_LIMIT(STARVE_LIMIT),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .bus_err   (bus_err)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [0:255];

    // Reference model: what the arbiter should show after the latest edge.
    bit          e_busy, e_who, e_we, e_flush, e_rst;
    bit          e_bus_err, e_if_done, e_d_done;
    logic [31:0] e_addr, e_wdata, e_if_rdata, e_d_rdata;
    int          e_wd, e_starve;

    // Memory responder: -1 random latency, -2 never ready, else fixed.
    int lat_sel = 0;
    int lat     = 0;
    bit armed   = 0;
    bit stray   = 0;

    bit f_ret = 0;
    bit d_ret = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'($urandom_range(0, 255)) << 2;
    endfunction

    task automatic model_reset();
        e_busy = 0; e_who = 0; e_we = 0; e_flush = 0; e_rst = 1;
        e_bus_err = 0; e_if_done = 0; e_d_done = 0;
        e_addr = '0; e_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
        e_wd = 0; e_starve = 0;
    endtask

    task automatic check_outputs();
        check("mem_req", mem_req, e_busy);
        if (e_busy || e_rst) begin
            check("mem_addr", mem_addr, e_addr);
            check("mem_we", mem_we, e_we);
            check("mem_wdata", mem_wdata, e_wdata);
        end
        check("if_done", if_done, e_if_done);
        check("d_done", d_done, e_d_done);
        check("if_rdata", if_rdata, e_if_rdata);
        check("d_rdata", d_rdata, e_d_rdata);
        check("bus_err", bus_err, e_bus_err);
    endtask

    // One clock cycle: memory response, stall check, edge, model update.
    task automatic cyc();
        bit          fe, de, starving, drop, abort, was_if_done, was_d_done;
        logic [31:0] val;
        if (!mem_req) armed = 0;
        if (mem_req && !armed) begin
            armed = 1;
            lat   = (lat_sel == -1) ? $urandom_range(0, 3) : lat_sel;
        end
        if (armed && lat == 0) begin
            mem_ready = 1'b1;
            mem_rdata = mem_m[mem_addr[9:2]];
            armed     = 0;
        end else begin
            if (armed && lat > 0) lat--;
            mem_ready = !mem_req && stray && ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
        end
        #1;
        check("stall_if", stall_if, if_req & ~e_if_done & ~if_flush);
        check("stall_mem", stall_mem, d_req & ~e_d_done);
        @(posedge clk);
        #1;
        e_rst = reset;
        if (reset) begin
            model_reset();
        end else begin
            was_if_done = e_if_done;
            was_d_done  = e_d_done;
            e_if_done   = 0;
            e_d_done    = 0;
            if (!e_busy) begin
                fe       = if_req && !if_flush && !was_if_done;
                de       = d_req && !was_d_done;
                starving = if_req && !if_flush && e_starve == STARVE_LIMIT;
                if (de && !starving) begin
                    e_busy = 1; e_who = 1; e_wd = 0;
                    e_addr = d_addr; e_we = d_we; e_wdata = d_wdata;
                    if (if_req && !if_flush && e_starve < STARVE_LIMIT)
                        e_starve++;
                end else if (fe) begin
                    e_busy = 1; e_who = 0; e_wd = 0;
                    e_addr = if_addr; e_we = 0; e_wdata = '0;
                    e_starve = 0;
                end
            end else begin
                drop  = e_flush || (!e_who && if_flush);
                abort = !mem_ready && TIMEOUT != 0 && e_wd + 1 == TIMEOUT;
                if (mem_ready || abort) begin
                    val     = abort ? 32'd0 : mem_m[e_addr[9:2]];
                    e_busy  = 0;
                    e_flush = 0;
                    if (abort) e_bus_err = 1;
                    if (!e_who) begin
                        if (!drop) begin
                            e_if_done  = 1;
                            e_if_rdata = val;
                        end
                    end else begin
                        e_d_done = 1;
                        if (abort || !e_we) e_d_rdata = val;
                    end
                    if (!abort && e_we) mem_m[e_addr[9:2]] = e_wdata;
                end else begin
                    e_wd++;
                    if (!e_who && if_flush) e_flush = 1;
                end
            end
            if (!if_req) e_starve = 0;
        end
        check_outputs();
    endtask

    task automatic wait_done(input bit fetch, input int maxc);
        for (int k = 0; k < maxc && !(fetch ? if_done : d_done); k++) cyc();
        check(fetch ? "wait_if_done" : "wait_d_done",
              fetch ? if_done : d_done, 1);
    endtask

    // Requesters hold through their done cycle and retire on the next one.
    task automatic drive_rand(input bit allow_new);
        if (f_ret) begin if_req = 0; f_ret = 0; end
        if (d_ret) begin d_req = 0; d_ret = 0; end
        if_flush = 0;
        if (if_done) begin
            f_ret = 1;
        end else if (allow_new && if_req && $urandom_range(0, 15) == 0) begin
            if_flush = 1;
            if_addr  = rand_addr();
        end else if (allow_new && !if_req && $urandom_range(0, 2) == 0) begin
            if_req  = 1;
            if_addr = rand_addr();
        end
        if (d_done) begin
            d_ret = 1;
        end else if (allow_new && !d_req && $urandom_range(0, 2) == 0) begin
            d_req   = 1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = rand_addr();
            d_wdata = $urandom;
        end
    endtask

    logic [31:0] old_rdata;
    int          f_served;
    int          busy_cnt;
    bit          dr, fr;

    initial begin
        for (int i = 0; i < 256; i++) mem_m[i] = $urandom;
        mem_m[2]  = 32'hE3A0_1005;
        mem_m[3]  = 32'h1122_3344;
        mem_m[64] = 32'h0000_0055;

        reset = 1; if_req = 0; if_addr = '0; if_flush = 0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_outputs();
        reset = 0;
        cyc();

        // Fetch only, zero-wait memory
        if_req = 1; if_addr = 32'h8;
        cyc();
        check("t1_mem_addr", mem_addr, 32'h8);
        check("t1_stall_c1", stall_if, 1);
        cyc();
        check("t1_if_done", if_done, 1);
        check("t1_if_rdata", if_rdata, 32'hE3A0_1005);
        cyc();
        if_req = 0;
        cyc();

        // Simultaneous fetch and load: data goes first
        if_req = 1; if_addr = 32'hC;
        d_req = 1; d_we = 0; d_addr = 32'h100;
        cyc();
        check("t2_data_first", mem_addr, 32'h100);
        cyc();
        check("t2_d_done", d_done, 1);
        check("t2_d_rdata", d_rdata, 32'h55);
        cyc();
        check("t2_fetch_next", mem_addr, 32'hC);
        d_req = 0;
        cyc();
        check("t2_if_rdata", if_rdata, 32'h1122_3344);
        cyc();
        if_req = 0;
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hCAFE_F00D;
        cyc();
        check("t2_store_we", mem_we, 1);
        check("t2_store_wdata", mem_wdata, 32'hCAFE_F00D);
        cyc();
        check("t2_store_done", d_done, 1);
        check("t2_store_rdata_held", d_rdata, 32'h55);
        cyc();
        d_req = 0;
        cyc();

        // Continuous data traffic with a waiting fetch
        if_req = 1; if_addr = 32'h30;
        d_req = 1; d_we = 0; d_addr = 32'h200;
        f_served = 0; dr = 0; fr = 0;
        for (int k = 0; k < 16; k++) begin
            if (dr) begin d_addr = d_addr + 32'd4; dr = 0; end
            if (fr) begin if_req = 0; fr = 0; end
            cyc();
            if (d_done) dr = 1;
            if (if_done) begin fr = 1; f_served++; end
        end
        check("t3_fetch_served", f_served, 1);
        if (fr) if_req = 0;
        if (!dr) wait_done(0, 20);
        cyc();
        d_req = 0;
        if_req = 0;
        cyc();

        // Flush while the fetch is on the bus
        old_rdata = if_rdata;
        lat_sel = 3;
        if_req = 1; if_addr = 32'h40;
        cyc();
        check("t4_fetch_granted", mem_addr, 32'h40);
        if_flush = 1; if_addr = 32'h44;
        cyc();
        if_flush = 0;
        for (int k = 0; k < 2; k++) begin
            cyc();
            check("t4_req_held", mem_req, 1);
        end
        lat_sel = 0;
        cyc();
        check("t4_no_done", if_done, 0);
        check("t4_rdata_kept", if_rdata, old_rdata);
        cyc();
        check("t4_refetch_addr", mem_addr, 32'h44);
        wait_done(1, 10);
        check("t4_refetch_rdata", if_rdata, mem_m[17]);
        cyc();
        if_req = 0;
        cyc();

        // Watchdog abort on a load that never completes
        lat_sel = -2;
        d_req = 1; d_we = 0; d_addr = 32'h80;
        busy_cnt = 0;
        for (int k = 0; k < 40 && !d_done; k++) begin
            cyc();
            if (mem_req) busy_cnt++;
        end
        check("t5_busy_cycles", busy_cnt, TIMEOUT);
        check("t5_d_done", d_done, 1);
        check("t5_d_rdata", d_rdata, 0);
        check("t5_bus_err", bus_err, 1);
        cyc();
        d_req = 0;
        lat_sel = 0;
        cyc();
        d_req = 1; d_addr = 32'h84;
        wait_done(0, 10);
        check("t5_after_rdata", d_rdata, mem_m[33]);
        check("t5_err_sticky", bus_err, 1);
        cyc();
        d_req = 0;
        cyc();

        // Reset in the middle of a data wait
        lat_sel = -2;
        d_req = 1; d_we = 0; d_addr = 32'h90;
        repeat (3) cyc();
        check("t6_busy", mem_req, 1);
        reset = 1; d_req = 0;
        cyc();
        check("t6_mem_req", mem_req, 0);
        check("t6_bus_err", bus_err, 0);
        check("t6_d_rdata", d_rdata, 0);
        reset = 0;
        lat_sel = -1;
        cyc();

        // Random traffic against the model
        stray = 1;
        f_ret = 0; d_ret = 0;
        for (int k = 0; k < 3000; k++) begin
            drive_rand(1);
            cyc();
        end
        for (int k = 0; k < 60; k++) begin
            drive_rand(0);
            cyc();
        end
        check("drain_idle", {29'd0, if_req, d_req, mem_req}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch stage (PCF/InstrF) and memory stage (ALUResultM/WriteDataM/ReadDataM).
- Grants one transaction at a time and registers the memory-side request.
- Returns read data with a one-cycle done pulse, and generates stall signals toward the hazard logic.
- Includes fetch-starvation protection, fetch flush on branch, and a bus-timeout watchdog.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port.
- STARVE_LIMIT, 4, number of consecutive data grants allowed while a fetch is pending before the fetch is forced.
- TIMEOUT, 16, cycles to wait for mem_ready before aborting; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- if_req  in  1  fetch request; held with if_addr until if_done
- if_addr  in  ADDR_W  fetch address (PCF)
- if_flush  in  1  cancel pending/in-flight fetch (BranchTakenE or PCSrcW)
- if_rdata  out  32  fetched instruction, valid while if_done=1
- if_done  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held with d_addr/d_we/d_wdata until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address (ALUResultM)
- d_wdata  in  32  store data (WriteDataM)
- d_rdata  out  32  load data (ReadDataM), valid while d_done=1
- d_done  out  1  one-cycle data completion pulse
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  32  memory write data, registered
- mem_rdata  in  32  memory read data, valid when mem_ready=1
- mem_ready  in  1  memory completion for the current request
- stall_if  out  1  stall fetch (to StallF/StallD)
- stall_mem  out  1  stall memory stage and everything upstream
- bus_err  out  1  sticky timeout flag

Behaviour:
- Reset: state ARB_IDLE. All outputs are 0: mem_*, *_done, *_rdata, bus_err. starve_cnt=0, wd_cnt=0, flush_pend=0.
- States:
  - ARB_IDLE: no transaction active.
  - ARB_FETCH, ARB_DATA: a transaction is outstanding; mem_req=1 and mem_addr/mem_we/mem_wdata stay stable.
- ARB_IDLE grant, evaluated each cycle; a requester whose done pulse is high this cycle is ignored:
  - If d_req and not (if_req & ~if_flush & starve_cnt==STARVE_LIMIT): go to ARB_DATA. Latch d_addr/d_we/d_wdata into mem_*.
  - Else if if_req & ~if_flush: go to ARB_FETCH. Latch if_addr; mem_we=0, mem_wdata=0.
  - mem_req=1 from the next cycle.
- Completion: when mem_ready=1 is sampled in ARB_FETCH/ARB_DATA:
  - Next cycle: mem_req=0, return to ARB_IDLE.
  - Corresponding done=1 and rdata=mem_rdata.
  - On a store, d_rdata keeps its previous value.
- Minimum latency is 2 cycles (req at c0, mem_req c1, mem_ready c1, done c2). mem_ready outside ARB_FETCH/ARB_DATA is ignored.
- Starvation counter:
  - starve_cnt increments (saturating at STARVE_LIMIT) on each data grant while if_req & ~if_flush.
  - Clears on a fetch grant or whenever if_req=0.
- Flush:
  - In ARB_IDLE, if_flush blocks the fetch grant.
  - In ARB_FETCH, if_flush sets flush_pend. The bus transaction still completes (mem_req is never withdrawn early). On completion if_done stays 0 and if_rdata is unchanged; flush_pend clears.
- Watchdog:
  - wd_cnt clears on entering ARB_FETCH/ARB_DATA and increments each busy cycle.
  - If wd_cnt reaches TIMEOUT with no mem_ready: abort as if complete, with rdata forced to 0, bus_err=1 (sticky until reset), and done pulsed (suppressed if flush_pend).
- stall_if = if_req & ~if_done & ~if_flush. stall_mem = d_req & ~d_done. Both combinational.
- Reset mid-transaction: the next edge forces ARB_IDLE with mem_req=0. The memory must tolerate an abandoned request.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum arb_state_t {ARB_IDLE, ARB_FETCH, ARB_DATA}
  - WORD_W=32
- Sub-module arb_watchdog: counter with clear/enable/expire output, parameter TIMEOUT, disabled when TIMEOUT=0.

Test Plan:
1. Fetch only: if_addr=0x00000008, mem_ready with mem_req, mem_rdata=0xE3A01005 -> mem_req c1, if_done c2 with if_rdata=0xE3A01005; stall_if=1 in c0-c1.
2. Simultaneous if_req (0x0C) and load d_req (0x100, mem_rdata=0x00000055) -> data first, d_done with d_rdata=0x55; then fetch granted. Follow with store 0x20/0xCAFEF00D -> mem_we=1, mem_wdata=0xCAFEF00D, d_rdata held at 0x55.
3. Starvation: continuous d_req, if_req held, STARVE_LIMIT=4 -> 4 data grants, then 5th grant goes to fetch, starve_cnt back to 0.
4. Flush during ARB_FETCH with mem_ready delayed 3 cycles -> mem_req held 3 cycles, no if_done, if_rdata unchanged, next if_req served normally.
5. Timeout: TIMEOUT=16, load with mem_ready never asserted -> mem_req drops after 16 busy cycles, d_done=1 with d_rdata=0, bus_err=1 and stays 1; next request still served.
6. reset asserted in ARB_DATA mid-wait -> next cycle mem_req=0, all outputs 0, bus_err=0, state ARB_IDLE.
